// File: rtl/gpioemu_bus_master.sv
// ============================================================================
// Module  : gpioemu_bus_master
// Brief   : Bus initiator that runs one multiply/popcount job on the gpioemu
//           peripheral (write operands, start, poll status, read W and L).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpioemu_bus_master #(
    parameter logic [15:0] ADDR_A1    = 16'h037F,
    parameter logic [15:0] ADDR_A2    = 16'h0388,
    parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
    parameter logic [15:0] ADDR_W     = 16'h0390,
    parameter logic [15:0] ADDR_L     = 16'h0398,
    parameter int          STROBE_CYC = 2,
    parameter int          POLL_GAP   = 4,
    parameter int          MAX_POLLS  = 256
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_product,
    output logic [23:0] rsp_ones,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam int CNT_MAX = (STROBE_CYC > POLL_GAP) ? STROBE_CYC : POLL_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int POLL_W  = $clog2(MAX_POLLS + 1);

    localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [POLL_W-1:0] POLL_LAST   = POLL_W'(MAX_POLLS - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_WR_A1 = 4'd1;
    localparam logic [3:0] S_WR_A2 = 4'd2;
    localparam logic [3:0] S_WR_GO = 4'd3;
    localparam logic [3:0] S_POLL  = 4'd4;
    localparam logic [3:0] S_GAP   = 4'd5;
    localparam logic [3:0] S_RD_W  = 4'd6;
    localparam logic [3:0] S_RD_L  = 4'd7;
    localparam logic [3:0] S_RESP  = 4'd8;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;
    localparam logic [1:0] PH_HOLD   = 2'd2;

    function automatic logic is_wr(input logic [3:0] s);
        return (s == S_WR_A1) || (s == S_WR_A2) || (s == S_WR_GO);
    endfunction

    function automatic logic is_rd(input logic [3:0] s);
        return (s == S_POLL) || (s == S_RD_W) || (s == S_RD_L);
    endfunction

    logic [3:0]        state, state_n;
    logic [1:0]        phase, phase_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [POLL_W-1:0] poll_cnt, poll_n;
    logic [23:0]       a1_q, a2_q;

    logic [15:0] addr_n;
    logic [31:0] data_n;
    logic        srd_n, swr_n;
    logic        rsp_valid_n, timeout_n;
    logic [31:0] product_n;
    logic [23:0] ones_n;

    logic accept, access_done, status_done, poll_last;
    logic [23:0] a1_src;

    assign cmd_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign accept      = cmd_ready && cmd_valid;
    assign access_done = (is_wr(state) || is_rd(state)) && (phase == PH_HOLD);
    assign status_done = (sdata_in[1:0] == 2'b11);
    assign poll_last   = (poll_cnt == POLL_LAST);
    assign a1_src      = accept ? cmd_a1 : a1_q;

    // State and output registers; bus outputs are registered so strobes never glitch.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            phase       <= PH_SETUP;
            cnt         <= '0;
            poll_cnt    <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            saddress    <= '0;
            sdata_out   <= '0;
            srd         <= 1'b0;
            swr         <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_ones    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            cnt         <= cnt_n;
            poll_cnt    <= poll_n;
            if (accept) begin
                a1_q <= cmd_a1;
                a2_q <= cmd_a2;
            end
            saddress    <= addr_n;
            sdata_out   <= data_n;
            srd         <= srd_n;
            swr         <= swr_n;
            rsp_valid   <= rsp_valid_n;
            rsp_product <= product_n;
            rsp_ones    <= ones_n;
            rsp_timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        poll_n  = poll_cnt;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_n = S_WR_A1;
                    phase_n = PH_SETUP;
                    cnt_n   = '0;
                    poll_n  = '0;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = S_POLL;
                    phase_n = PH_SETUP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_RD_W, S_RD_L: begin
                case (phase)
                    PH_SETUP: begin
                        phase_n = PH_STROBE;
                        cnt_n   = '0;
                    end
                    PH_STROBE: begin
                        if (cnt == STROBE_LAST) begin
                            phase_n = PH_HOLD;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    default: begin
                        phase_n = PH_SETUP;
                        cnt_n   = '0;
                        case (state)
                            S_WR_A1: state_n = S_WR_A2;
                            S_WR_A2: state_n = S_WR_GO;
                            S_WR_GO: state_n = S_POLL;
                            S_RD_W:  state_n = S_RD_L;
                            S_RD_L:  state_n = S_RESP;
                            default: begin
                                // Status decision uses the read data sampled at the end of HOLD.
                                if (status_done) begin
                                    state_n = S_RD_W;
                                end else begin
                                    poll_n = poll_cnt + 1'b1;
                                    if (poll_last) begin
                                        state_n = S_RESP;
                                    end else if (POLL_GAP == 0) begin
                                        state_n = S_POLL;
                                    end else begin
                                        state_n = S_GAP;
                                    end
                                end
                            end
                        endcase
                    end
                endcase
            end
            default: begin
                state_n = S_IDLE;
                phase_n = PH_SETUP;
                cnt_n   = '0;
                poll_n  = '0;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next state so they align with it.
    always_comb begin
        addr_n      = saddress;
        data_n      = sdata_out;
        srd_n       = (phase_n == PH_STROBE) && is_rd(state_n);
        swr_n       = (phase_n == PH_STROBE) && is_wr(state_n);
        rsp_valid_n = (state_n == S_RESP);
        product_n   = rsp_product;
        ones_n      = rsp_ones;
        timeout_n   = rsp_timeout;
        if (phase_n == PH_SETUP) begin
            case (state_n)
                S_WR_A1: begin
                    addr_n = ADDR_A1;
                    data_n = {8'h00, a1_src};
                end
                S_WR_A2: begin
                    addr_n = ADDR_A2;
                    data_n = {8'h00, a2_q};
                end
                S_WR_GO: begin
                    addr_n = ADDR_CTRL;
                    data_n = 32'h0000_0001;
                end
                S_POLL:  addr_n = ADDR_CTRL;
                S_RD_W:  addr_n = ADDR_W;
                S_RD_L:  addr_n = ADDR_L;
                default: ;
            endcase
        end
        if (access_done) begin
            case (state)
                S_RD_W: product_n = sdata_in;
                S_RD_L: begin
                    ones_n    = sdata_in[23:0];
                    timeout_n = 1'b0;
                end
                S_POLL: begin
                    if (!status_done && poll_last) begin
                        product_n = '0;
                        ones_n    = '0;
                        timeout_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpioemu_bus_master.sv
// Randomized bench for gpioemu_bus_master: a slave model answers the bus, a
// per-cycle monitor checks accesses against an expected transaction list.
`timescale 1ns/1ps
`default_nettype none

module tb_gpioemu_bus_master;

    localparam int S = 2;
    localparam int G = 3;
    localparam int M = 4;
    localparam logic [15:0] A_A1   = 16'h037F;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_product;
    logic [23:0] rsp_ones;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    always #5 clk = ~clk;

    gpioemu_bus_master #(
        .STROBE_CYC (S),
        .POLL_GAP   (G),
        .MAX_POLLS  (M)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a1      (cmd_a1),
        .cmd_a2      (cmd_a2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_ones    (rsp_ones),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .saddress    (saddress),
        .srd         (srd),
        .swr         (swr),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: poll k of a job reports done when k reaches done_after (0 = never).
    // L carries the popcount of the low product word, with junk in the unused top byte.
    int          done_after = 1;
    int          poll_seen;
    logic [23:0] s_a1, s_a2;
    logic [1:0]  stat;
    logic [29:0] noise;
    logic [7:0]  junk;
    logic        srd_d, swr_d;
    logic [47:0] s_prod;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            srd_d     <= 1'b0;
            swr_d     <= 1'b0;
            poll_seen <= 0;
            stat      <= 2'b00;
            noise     <= '0;
            junk      <= '0;
            s_a1      <= '0;
            s_a2      <= '0;
        end else begin
            srd_d <= srd;
            swr_d <= swr;
            if (swr && !swr_d) begin
                if (saddress == A_A1)   s_a1 <= sdata_out[23:0];
                if (saddress == A_A2)   s_a2 <= sdata_out[23:0];
                if (saddress == A_CTRL) poll_seen <= 0;
            end
            if (srd && !srd_d) begin
                junk <= 8'($urandom);
                if (saddress == A_CTRL) begin
                    poll_seen <= poll_seen + 1;
                    noise     <= 30'($urandom);
                    stat      <= (done_after != 0 && poll_seen + 1 >= done_after) ?
                                 2'b11 : 2'($urandom_range(0, 2));
                end
            end
        end
    end

    always_comb begin
        s_prod = {24'h0, s_a1} * {24'h0, s_a2};
        case (saddress)
            A_CTRL:  sdata_in = {noise, stat};
            A_W:     sdata_in = s_prod[31:0];
            A_L:     sdata_in = {junk, 24'($countones(s_prod[31:0]))};
            default: sdata_in = {junk, 24'hDEAD00};
        endcase
    end

    // Per-cycle compare process: bus protocol, access sequence, response stability.
    logic        p_rd, p_wr, p_rv, p_t, last_poll;
    logic [15:0] p_addr;
    logic [31:0] p_data, p_p;
    logic [23:0] p_o;
    int          strobe_len, low_len;
    acc_t        e;

    always @(negedge clk) begin
        if (!n_reset) begin
            p_rd = 1'b0; p_wr = 1'b0; p_rv = 1'b0; p_t = 1'b0; last_poll = 1'b0;
            p_addr = '0; p_data = '0; p_p = '0; p_o = '0;
            strobe_len = 0; low_len = 0;
        end else begin
            chk("ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            chk("strobe_exclusive", 64'(srd && swr), 64'(0));
            if ((srd || swr) && !(p_rd || p_wr)) begin
                chk("setup_addr", 64'(saddress), 64'(p_addr));
                if (swr) chk("setup_data", 64'(sdata_out), 64'(p_data));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got addr %0h wr %0b, required none", saddress, swr);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_kind", 64'(swr), 64'(e.wr));
                    chk("acc_addr", 64'(saddress), 64'(e.addr));
                    if (e.wr) chk("acc_data", 64'(sdata_out), 64'(e.data));
                    if (!(e.wr && e.addr == A_A1))
                        chk("acc_gap", 64'(low_len),
                            64'((last_poll && srd && saddress == A_CTRL) ? G + 2 : 2));
                end
                last_poll  = srd && (saddress == A_CTRL);
                strobe_len = 1;
            end else if (srd || swr) begin
                chk("strobe_addr_stable", 64'(saddress), 64'(p_addr));
                chk("strobe_data_stable", 64'(sdata_out), 64'(p_data));
                chk("strobe_kind_stable", 64'({srd, swr}), 64'({p_rd, p_wr}));
                strobe_len++;
            end else if (p_rd || p_wr) begin
                chk("strobe_len", 64'(strobe_len), 64'(S));
                chk("hold_addr", 64'(saddress), 64'(p_addr));
                if (p_wr) chk("hold_data", 64'(sdata_out), 64'(p_data));
                low_len = 1;
            end else begin
                low_len++;
            end
            if (p_rv && rsp_valid) begin
                chk("rsp_product_stable", 64'(rsp_product), 64'(p_p));
                chk("rsp_ones_stable", 64'(rsp_ones), 64'(p_o));
                chk("rsp_timeout_stable", 64'(rsp_timeout), 64'(p_t));
            end
            p_rd = srd; p_wr = swr; p_addr = saddress; p_data = sdata_out;
            p_rv = rsp_valid; p_p = rsp_product; p_o = rsp_ones; p_t = rsp_timeout;
        end
    end

    // Issues one job from a negedge and returns the response seen; model checks inside.
    task automatic do_job(input logic [23:0] a1, input logic [23:0] a2, input int k,
                          output logic [31:0] p, output logic [23:0] o, output logic t,
                          output int lat);
        int          n, w, exp_lat;
        bit          to;
        logic [47:0] prod;
        logic [31:0] exp_p;
        logic [23:0] exp_o;
        to   = (k == 0) || (k > M);
        n    = to ? M : k;
        prod = {24'h0, a1} * {24'h0, a2};
        exp_p = to ? 32'h0 : prod[31:0];
        exp_o = to ? 24'h0 : 24'($countones(prod[31:0]));
        exp_lat = (3 + n) * (S + 2) + (n - 1) * G + (to ? 0 : 2 * (S + 2)) + 1;
        done_after = k;
        exp_q.push_back({1'b1, A_A1, {8'h0, a1}});
        exp_q.push_back({1'b1, A_A2, {8'h0, a2}});
        exp_q.push_back({1'b1, A_CTRL, 32'h1});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, A_CTRL, 32'h0});
        if (!to) begin
            exp_q.push_back({1'b0, A_W, 32'h0});
            exp_q.push_back({1'b0, A_L, 32'h0});
        end
        cmd_a1 = a1;
        cmd_a2 = a2;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            $display("FAIL accept_wait: cmd_ready stayed 0, required 1");
            $fatal(1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", 64'(busy), 64'(1));
        lat = 1;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom);
            cmd_a1    = 24'($urandom);
            cmd_a2    = 24'($urandom);
            rsp_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            $display("FAIL rsp_wait: rsp_valid stayed 0, required 1");
            $fatal(1);
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_product", 64'(rsp_product), 64'(exp_p));
        chk("rsp_ones", 64'(rsp_ones), 64'(exp_o));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(to));
        chk("accesses_left", 64'(exp_q.size()), 64'(0));
        chk("cmd_ready_in_resp", 64'(cmd_ready), 64'(0));
        p = rsp_product;
        o = rsp_ones;
        t = rsp_timeout;
    endtask

    // Completes the response handshake; optionally presents the next command meanwhile.
    task automatic finish_rsp(input int delay, input bit pre,
                              input logic [23:0] na1, input logic [23:0] na2);
        bit r;
        r = rsp_ready;
        if (!r) begin
            for (int i = 0; i < delay; i++) begin
                @(posedge clk); #1;
                cmd_valid = pre; cmd_a1 = na1; cmd_a2 = na2; rsp_ready = 1'b0;
                @(negedge clk);
                chk("rsp_held", 64'(rsp_valid), 64'(1));
                chk("cmd_ready_waits", 64'(cmd_ready), 64'(0));
            end
            @(posedge clk); #1;
            cmd_valid = pre; cmd_a1 = na1; cmd_a2 = na2; rsp_ready = 1'b1;
            @(negedge clk);
            chk("rsp_before_hs", 64'(rsp_valid), 64'(1));
        end
        @(posedge clk); #1;
        cmd_valid = pre; cmd_a1 = na1; cmd_a2 = na2; rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_after_hs", 64'(rsp_valid), 64'(0));
        chk("idle_after_hs", 64'(cmd_ready), 64'(1));
    endtask

    function automatic logic [23:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 24'h000000;
            1:       return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] p;
        logic [23:0] o;
        logic        t;
        int          lat, w;
        logic [23:0] ca1, ca2, na1, na2;
        int          ck, nk;

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_strobes", 64'({srd, swr}), 64'(0));
        chk("reset_saddress", 64'(saddress), 64'(0));
        chk("reset_sdata_out", 64'(sdata_out), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_timeout, rsp_product, rsp_ones}), 64'(0));
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(negedge clk);

        do_job(24'd3, 24'd5, 1, p, o, t, lat);
        chk("lit_3x5_product", 64'(p), 64'(15));
        chk("lit_3x5_ones", 64'(o), 64'(4));
        chk("lit_3x5_timeout", 64'(t), 64'(0));
        chk("lit_min_latency", 64'(lat), 64'(6 * (S + 2) + 1));
        finish_rsp(0, 1'b0, 24'h0, 24'h0);

        do_job(24'hFFFFFF, 24'hFFFFFF, 1, p, o, t, lat);
        chk("lit_max_product", 64'(p), 64'(32'hFE000001));
        chk("lit_max_ones", 64'(o), 64'(8));
        finish_rsp(2, 1'b0, 24'h0, 24'h0);

        do_job(24'h000123, 24'h000456, 4, p, o, t, lat);
        chk("lit_4poll_product", 64'(p), 64'(32'h0004EDC2));
        chk("lit_4poll_latency", 64'(lat), 64'(46));
        chk("lit_4poll_timeout", 64'(t), 64'(0));
        finish_rsp(1, 1'b0, 24'h0, 24'h0);

        do_job(24'd7, 24'd9, 0, p, o, t, lat);
        chk("lit_timeout_flag", 64'(t), 64'(1));
        chk("lit_timeout_data", 64'({p, o}), 64'(0));
        chk("lit_timeout_latency", 64'(lat), 64'(38));
        finish_rsp(10, 1'b1, 24'h00ABCD, 24'h000011);

        do_job(24'h00ABCD, 24'h000011, 2, p, o, t, lat);
        chk("lit_queued_product", 64'(p), 64'(32'h000B689D));
        finish_rsp(0, 1'b0, 24'h0, 24'h0);

        na1 = pick_operand();
        na2 = pick_operand();
        nk  = $urandom_range(0, M + 1);
        for (int j = 0; j < 30; j++) begin
            bit pre;
            ca1 = na1; ca2 = na2; ck = nk;
            na1 = pick_operand();
            na2 = pick_operand();
            nk  = $urandom_range(0, M + 1);
            pre = (j < 29) ? 1'($urandom) : 1'b0;
            do_job(ca1, ca2, ck, p, o, t, lat);
            finish_rsp($urandom_range(0, 4), pre, na1, na2);
        end

        // Reset in the middle of a status-read strobe.
        done_after = 0;
        exp_q.push_back({1'b1, A_A1, 32'h1});
        exp_q.push_back({1'b1, A_A2, 32'h2});
        exp_q.push_back({1'b1, A_CTRL, 32'h1});
        for (int i = 0; i < M; i++) exp_q.push_back({1'b0, A_CTRL, 32'h0});
        cmd_a1 = 24'd1; cmd_a2 = 24'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(srd && saddress == A_CTRL) && w < 500);
        chk("reach_poll_strobe", 64'(srd && saddress == A_CTRL), 64'(1));
        #1 n_reset = 1'b0;
        #1;
        chk("async_srd_drop", 64'(srd), 64'(0));
        chk("async_busy_drop", 64'(busy), 64'(0));
        chk("async_saddress", 64'(saddress), 64'(0));
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #2;
        n_reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 64'({rsp_valid, srd, swr}), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
